// File: rtl/commit_pkg.sv
// Shared definitions for the commit/result producer: CSR addresses, memory
// width encodings and the shadow CSR bundle.
package commit_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam logic [6:0] W8  = 7'd8;
  localparam logic [6:0] W16 = 7'd16;
  localparam logic [6:0] W32 = 7'd32;

  typedef struct packed {
    logic [31:0] mstatus;
    logic [31:0] mscratch;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } csr_state_t;

  // Byte-keep mask for a lane of the given width in bits.
  function automatic logic [31:0] width_keep(input logic [6:0] w);
    case (w)
      W8:      width_keep = 32'h0000_00FF;
      W16:     width_keep = 32'h0000_FFFF;
      W32:     width_keep = 32'hFFFF_FFFF;
      default: width_keep = 32'h00FF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_norm.sv
// Turns a word address, byte mask and word data into the byte address,
// access width and right-aligned data of the accessed lanes.
module mem_lane_norm
  import commit_pkg::*;
(
  input  logic [3:0]  mask_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [6:0]  width_o,
  output logic [31:0] data_o
);

  logic [1:0] off;
  logic [2:0] cnt;

  always_comb begin
    off = 2'd0;
    cnt = 3'd0;
    // Descending scan so the lowest set bit wins.
    for (int i = 3; i >= 0; i--) begin
      if (mask_i[i]) off = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, mask_i[i]};
    end
  end

  assign valid_o = |mask_i;
  assign addr_o  = addr_i + {30'd0, off};
  assign width_o = {1'b0, cnt, 3'b000};
  assign data_o  = (data_i >> {off, 3'b000}) & width_keep(width_o);

endmodule

// File: rtl/commit_result_tracker.sv
// Registers per-retire RVFI pulses into the checker's commit packet and keeps
// the shadow GPR/CSR/pc state that the packet reports.
module commit_result_tracker
  import commit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rvfi_valid,
  input  logic [63:0]   rvfi_order,
  input  logic [31:0]   rvfi_insn,
  input  logic [31:0]   rvfi_pc_rdata,
  input  logic [31:0]   rvfi_pc_wdata,
  input  logic          rvfi_trap,
  input  logic [31:0]   trap_cause,
  input  logic [4:0]    rvfi_rd_addr,
  input  logic [31:0]   rvfi_rd_wdata,
  input  logic [31:0]   rvfi_mem_addr,
  input  logic [3:0]    rvfi_mem_rmask,
  input  logic [3:0]    rvfi_mem_wmask,
  input  logic [31:0]   rvfi_mem_rdata,
  input  logic [31:0]   rvfi_mem_wdata,
  input  logic          csr_we,
  input  logic [11:0]   csr_addr,
  input  logic [31:0]   csr_wdata,
  output logic          instCommit_valid,
  output logic [31:0]   instCommit_inst,
  output logic [31:0]   instCommit_pc,
  output logic [1023:0] result_regs,
  output logic [31:0]   result_pc,
  output logic [31:0]   result_csr_misa,
  output logic [31:0]   result_csr_mstatus,
  output logic [31:0]   result_csr_mscratch,
  output logic [31:0]   result_csr_mtvec,
  output logic [31:0]   result_csr_mepc,
  output logic [31:0]   result_csr_mcause,
  output logic [31:0]   result_csr_mtval,
  output logic          event_valid,
  output logic [31:0]   event_cause,
  output logic [31:0]   event_exceptionPC,
  output logic [31:0]   event_exceptionInst,
  output logic          mem_read_valid,
  output logic [31:0]   mem_read_addr,
  output logic [6:0]    mem_read_memWidth,
  output logic [31:0]   mem_read_data,
  output logic          mem_write_valid,
  output logic [31:0]   mem_write_addr,
  output logic [6:0]    mem_write_memWidth,
  output logic [31:0]   mem_write_data,
  output logic          order_error
);

  logic ok_ret, trap_ret, gpr_we;
  assign ok_ret   = rvfi_valid & ~rvfi_trap;
  assign trap_ret = rvfi_valid & rvfi_trap;
  assign gpr_we   = ok_ret & (rvfi_rd_addr != 5'd0);

  // Lane normalisation for the load and store sides.
  logic        rd_v, wr_v;
  logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [6:0]  rd_w, wr_w;

  mem_lane_norm u_read_norm (
    .mask_i (rvfi_mem_rmask), .addr_i (rvfi_mem_addr), .data_i (rvfi_mem_rdata),
    .valid_o(rd_v), .addr_o(rd_addr), .width_o(rd_w), .data_o(rd_data)
  );

  mem_lane_norm u_write_norm (
    .mask_i (rvfi_mem_wmask), .addr_i (rvfi_mem_addr), .data_i (rvfi_mem_wdata),
    .valid_o(wr_v), .addr_o(wr_addr), .width_o(wr_w), .data_o(wr_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_gpr
      if (gi == 0) begin : g_zero
        assign result_regs[31:0] = '0;
      end else begin : g_reg
        logic [31:0] gpr_q, gpr_d;
        always_comb begin
          gpr_d = gpr_q;
          if (gpr_we && (rvfi_rd_addr == 5'(gi))) gpr_d = rvfi_rd_wdata;
        end
        always_ff @(posedge clock or posedge reset) begin
          if (reset) gpr_q <= '0;
          else       gpr_q <= gpr_d;
        end
        assign result_regs[32*gi +: 32] = gpr_q;
      end
    end
  endgenerate

  csr_state_t  csr_q, csr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    csr_d = csr_q;
    pc_d  = pc_q;
    if (trap_ret) begin
      // Trap vector comes from the pre-instruction mtvec; csr_we is ignored.
      csr_d.mepc   = rvfi_pc_rdata;
      csr_d.mcause = trap_cause;
      csr_d.mtval  = '0;
      pc_d         = csr_q.mtvec & ~32'h3;
    end else if (ok_ret) begin
      pc_d = rvfi_pc_wdata;
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS:  csr_d.mstatus  = csr_wdata;
          CSR_MSCRATCH: csr_d.mscratch = csr_wdata;
          CSR_MTVEC:    csr_d.mtvec    = csr_wdata;
          CSR_MEPC:     csr_d.mepc     = csr_wdata;
          CSR_MCAUSE:   csr_d.mcause   = csr_wdata;
          CSR_MTVAL:    csr_d.mtval    = csr_wdata;
          default:      ;
        endcase
      end
    end
  end

  logic [63:0] expected_q, expected_d;
  logic        order_error_q, order_error_d;

  always_comb begin
    expected_d    = expected_q;
    order_error_d = order_error_q;
    if (rvfi_valid) begin
      expected_d = rvfi_order + 64'd1;
      if (rvfi_order != expected_q) order_error_d = 1'b1;
    end
  end

  logic        commit_valid_q, event_valid_q, mr_valid_q, mw_valid_q;
  logic [31:0] inst_q, ipc_q, ev_cause_q, ev_pc_q, ev_inst_q;
  logic [31:0] mr_addr_q, mr_data_q, mw_addr_q, mw_data_q;
  logic [6:0]  mr_w_q, mw_w_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csr_q          <= '0;
      pc_q           <= RESET_PC;
      expected_q     <= '0;
      order_error_q  <= 1'b0;
      commit_valid_q <= 1'b0;
      event_valid_q  <= 1'b0;
      mr_valid_q     <= 1'b0;
      mw_valid_q     <= 1'b0;
      inst_q         <= '0;
      ipc_q          <= '0;
      ev_cause_q     <= '0;
      ev_pc_q        <= '0;
      ev_inst_q      <= '0;
      mr_addr_q      <= '0;
      mr_data_q      <= '0;
      mr_w_q         <= '0;
      mw_addr_q      <= '0;
      mw_data_q      <= '0;
      mw_w_q         <= '0;
    end else begin
      csr_q          <= csr_d;
      pc_q           <= pc_d;
      expected_q     <= expected_d;
      order_error_q  <= order_error_d;
      commit_valid_q <= rvfi_valid;
      event_valid_q  <= trap_ret;
      mr_valid_q     <= ok_ret & rd_v;
      mw_valid_q     <= ok_ret & wr_v;
      if (rvfi_valid) begin
        inst_q <= rvfi_insn;
        ipc_q  <= rvfi_pc_rdata;
      end
      if (trap_ret) begin
        ev_cause_q <= trap_cause;
        ev_pc_q    <= rvfi_pc_rdata;
        ev_inst_q  <= rvfi_insn;
      end
      if (ok_ret && rd_v) begin
        mr_addr_q <= rd_addr;
        mr_data_q <= rd_data;
        mr_w_q    <= rd_w;
      end
      if (ok_ret && wr_v) begin
        mw_addr_q <= wr_addr;
        mw_data_q <= wr_data;
        mw_w_q    <= wr_w;
      end
    end
  end

  assign instCommit_valid    = commit_valid_q;
  assign instCommit_inst     = inst_q;
  assign instCommit_pc       = ipc_q;
  assign result_pc           = pc_q;
  assign result_csr_misa     = MISA_VAL;
  assign result_csr_mstatus  = csr_q.mstatus;
  assign result_csr_mscratch = csr_q.mscratch;
  assign result_csr_mtvec    = csr_q.mtvec;
  assign result_csr_mepc     = csr_q.mepc;
  assign result_csr_mcause   = csr_q.mcause;
  assign result_csr_mtval    = csr_q.mtval;
  assign event_valid         = event_valid_q;
  assign event_cause         = ev_cause_q;
  assign event_exceptionPC   = ev_pc_q;
  assign event_exceptionInst = ev_inst_q;
  assign mem_read_valid      = mr_valid_q;
  assign mem_read_addr       = mr_addr_q;
  assign mem_read_memWidth   = mr_w_q;
  assign mem_read_data       = mr_data_q;
  assign mem_write_valid     = mw_valid_q;
  assign mem_write_addr      = mw_addr_q;
  assign mem_write_memWidth  = mw_w_q;
  assign mem_write_data      = mw_data_q;
  assign order_error         = order_error_q;

endmodule

// File: tb/tb_commit_result_tracker.sv
// Scoreboard bench: stimulus pushes hand-computed packets, a negedge monitor
// pops and compares each commit the tracker presents.
module tb_commit_result_tracker;

  logic          clock = 1'b0;
  logic          reset;
  logic          rvfi_valid;
  logic [63:0]   rvfi_order;
  logic [31:0]   rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
  logic          rvfi_trap;
  logic [31:0]   trap_cause;
  logic [4:0]    rvfi_rd_addr;
  logic [31:0]   rvfi_rd_wdata, rvfi_mem_addr;
  logic [3:0]    rvfi_mem_rmask, rvfi_mem_wmask;
  logic [31:0]   rvfi_mem_rdata, rvfi_mem_wdata;
  logic          csr_we;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata;
  logic          instCommit_valid;
  logic [31:0]   instCommit_inst, instCommit_pc;
  logic [1023:0] result_regs;
  logic [31:0]   result_pc, result_csr_misa, result_csr_mstatus, result_csr_mscratch;
  logic [31:0]   result_csr_mtvec, result_csr_mepc, result_csr_mcause, result_csr_mtval;
  logic          event_valid;
  logic [31:0]   event_cause, event_exceptionPC, event_exceptionInst;
  logic          mem_read_valid, mem_write_valid;
  logic [31:0]   mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
  logic [6:0]    mem_read_memWidth, mem_write_memWidth;
  logic          order_error;

  commit_result_tracker dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_trap(rvfi_trap), .trap_cause(trap_cause), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .instCommit_valid(instCommit_valid), .instCommit_inst(instCommit_inst),
    .instCommit_pc(instCommit_pc), .result_regs(result_regs), .result_pc(result_pc),
    .result_csr_misa(result_csr_misa), .result_csr_mstatus(result_csr_mstatus),
    .result_csr_mscratch(result_csr_mscratch), .result_csr_mtvec(result_csr_mtvec),
    .result_csr_mepc(result_csr_mepc), .result_csr_mcause(result_csr_mcause),
    .result_csr_mtval(result_csr_mtval), .event_valid(event_valid),
    .event_cause(event_cause), .event_exceptionPC(event_exceptionPC),
    .event_exceptionInst(event_exceptionInst), .mem_read_valid(mem_read_valid),
    .mem_read_addr(mem_read_addr), .mem_read_memWidth(mem_read_memWidth),
    .mem_read_data(mem_read_data), .mem_write_valid(mem_write_valid),
    .mem_write_addr(mem_write_addr), .mem_write_memWidth(mem_write_memWidth),
    .mem_write_data(mem_write_data), .order_error(order_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst, pc, next_pc;
    int          reg_idx;
    logic [31:0] reg_val;
    logic [31:0] mstatus, mscratch, mtvec, mepc, mcause, mtval;
    logic        ev_valid;
    logic [31:0] ev_cause, ev_pc;
    logic        mr_valid;
    logic [31:0] mr_addr, mr_data;
    logic [6:0]  mr_w;
    logic        mw_valid;
    logic [31:0] mw_addr, mw_data;
    logic [6:0]  mw_w;
    logic        oerr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented commit against the oldest expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (instCommit_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit actual pc=%h required none", instCommit_pc);
        end else begin
          m = q.pop_front();
          $display("commit pc=%h inst=%h next_pc=%h ev=%0b rd=%0b wr=%0b oerr=%0b",
                   instCommit_pc, instCommit_inst, result_pc, event_valid,
                   mem_read_valid, mem_write_valid, order_error);
          chk("inst", instCommit_inst, m.inst);
          chk("pc", instCommit_pc, m.pc);
          chk("next_pc", result_pc, m.next_pc);
          chk("gpr", result_regs[32*m.reg_idx +: 32], m.reg_val);
          chk("gpr0", result_regs[31:0], 32'h0);
          chk("misa", result_csr_misa, 32'h4000_0100);
          chk("mstatus", result_csr_mstatus, m.mstatus);
          chk("mscratch", result_csr_mscratch, m.mscratch);
          chk("mtvec", result_csr_mtvec, m.mtvec);
          chk("mepc", result_csr_mepc, m.mepc);
          chk("mcause", result_csr_mcause, m.mcause);
          chk("mtval", result_csr_mtval, m.mtval);
          chk("event_valid", 32'(event_valid), 32'(m.ev_valid));
          chk("mem_read_valid", 32'(mem_read_valid), 32'(m.mr_valid));
          chk("mem_write_valid", 32'(mem_write_valid), 32'(m.mw_valid));
          chk("order_error", 32'(order_error), 32'(m.oerr));
          if (m.ev_valid) begin
            chk("event_cause", event_cause, m.ev_cause);
            chk("event_pc", event_exceptionPC, m.ev_pc);
            chk("event_inst", event_exceptionInst, m.inst);
          end
          if (m.mr_valid) begin
            chk("mem_read_addr", mem_read_addr, m.mr_addr);
            chk("mem_read_width", 32'(mem_read_memWidth), 32'(m.mr_w));
            chk("mem_read_data", mem_read_data, m.mr_data);
          end
          if (m.mw_valid) begin
            chk("mem_write_addr", mem_write_addr, m.mw_addr);
            chk("mem_write_width", 32'(mem_write_memWidth), 32'(m.mw_w));
            chk("mem_write_data", mem_write_data, m.mw_data);
          end
        end
      end else begin
        chk("idle_valids", {29'd0, event_valid, mem_read_valid, mem_write_valid}, 32'h0);
      end
    end
  end

  task automatic idle();
    rvfi_valid = 0; rvfi_order = '0; rvfi_insn = '0; rvfi_pc_rdata = '0;
    rvfi_pc_wdata = '0; rvfi_trap = 0; trap_cause = '0; rvfi_rd_addr = '0;
    rvfi_rd_wdata = '0; rvfi_mem_addr = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
    rvfi_mem_rdata = '0; rvfi_mem_wdata = '0; csr_we = 0; csr_addr = '0; csr_wdata = '0;
  endtask

  task automatic drive(input logic [63:0] ord, input logic [31:0] insn, input logic [31:0] pcr,
                       input logic [31:0] pcw, input logic [4:0] rd, input logic [31:0] rdw);
    rvfi_valid = 1; rvfi_order = ord; rvfi_insn = insn; rvfi_pc_rdata = pcr;
    rvfi_pc_wdata = pcw; rvfi_rd_addr = rd; rvfi_rd_wdata = rdw;
    e.inst = insn; e.pc = pcr;
    e.ev_valid = 0; e.mr_valid = 0; e.mw_valid = 0;
  endtask

  task automatic go();
    q.push_back(e);
    @(posedge clock);
    #1;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    e = '{default: '0};
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result_pc", result_pc, 32'h0);
    chk("rst_regs_zero", 32'(|result_regs), 32'h0);
    chk("rst_valids", {28'd0, instCommit_valid, event_valid, mem_read_valid, mem_write_valid}, 32'h0);
    chk("rst_order_error", 32'(order_error), 32'h0);
    chk("rst_misa", result_csr_misa, 32'h4000_0100);
    reset = 0;
    @(posedge clock);
    #1;

    // addi x5 = 0x1234
    drive(64'd0, 32'h1234_0293, 32'h0, 32'h4, 5'd5, 32'h1234);
    e.next_pc = 32'h4; e.reg_idx = 5; e.reg_val = 32'h1234;
    go();
    // write to x0 must be dropped
    drive(64'd1, 32'h0000_0013, 32'h4, 32'h8, 5'd0, 32'hFFFF);
    e.next_pc = 32'h8; e.reg_idx = 0; e.reg_val = 32'h0;
    go();
    // lb from byte lane 2
    drive(64'd2, 32'h1020_0303, 32'h8, 32'hC, 5'd6, 32'hFFFF_FFBB);
    rvfi_mem_addr = 32'h100; rvfi_mem_rmask = 4'b0100; rvfi_mem_rdata = 32'hAABB_CCDD;
    e.next_pc = 32'hC; e.reg_idx = 6; e.reg_val = 32'hFFFF_FFBB;
    e.mr_valid = 1; e.mr_addr = 32'h102; e.mr_w = 7'd8; e.mr_data = 32'hBB;
    go();
    // sh to upper half
    drive(64'd3, 32'h20A0_1123, 32'hC, 32'h10, 5'd0, 32'h0);
    rvfi_mem_addr = 32'h200; rvfi_mem_wmask = 4'b1100; rvfi_mem_wdata = 32'h5566_7788;
    e.next_pc = 32'h10; e.reg_idx = 0; e.reg_val = 32'h0;
    e.mw_valid = 1; e.mw_addr = 32'h202; e.mw_w = 7'd16; e.mw_data = 32'h5566;
    go();
    // csrw mtvec
    drive(64'd4, 32'h3052_9073, 32'h10, 32'h14, 5'd0, 32'h0);
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h8000_0101;
    e.next_pc = 32'h14; e.mtvec = 32'h8000_0101;
    go();
    // lw full word plus csrw mscratch
    drive(64'd5, 32'h3000_2383, 32'h14, 32'h18, 5'd7, 32'h0102_0304);
    rvfi_mem_addr = 32'h300; rvfi_mem_rmask = 4'b1111; rvfi_mem_rdata = 32'h0102_0304;
    csr_we = 1; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
    e.next_pc = 32'h18; e.reg_idx = 7; e.reg_val = 32'h0102_0304; e.mscratch = 32'hDEAD_BEEF;
    e.mr_valid = 1; e.mr_addr = 32'h300; e.mr_w = 7'd32; e.mr_data = 32'h0102_0304;
    go();
    // sb to top byte plus csrw mstatus
    drive(64'd6, 32'h4000_01A3, 32'h18, 32'h1C, 5'd0, 32'h0);
    rvfi_mem_addr = 32'h400; rvfi_mem_wmask = 4'b1000; rvfi_mem_wdata = 32'h9A00_0000;
    csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h1800;
    e.next_pc = 32'h1C; e.reg_idx = 0; e.reg_val = 32'h0; e.mstatus = 32'h1800;
    e.mw_valid = 1; e.mw_addr = 32'h403; e.mw_w = 7'd8; e.mw_data = 32'h9A;
    go();
    // csrw mtval
    drive(64'd7, 32'h3430_9073, 32'h1C, 32'h20, 5'd0, 32'h0);
    csr_we = 1; csr_addr = 12'h343; csr_wdata = 32'h77;
    e.next_pc = 32'h20; e.mtval = 32'h77;
    go();
    // write to an unimplemented CSR changes nothing
    drive(64'd8, 32'h7C00_9073, 32'h20, 32'h24, 5'd0, 32'h0);
    csr_we = 1; csr_addr = 12'h7C0; csr_wdata = 32'hFFFF_FFFF;
    e.next_pc = 32'h24;
    go();
    // trap: rd, csr and memory side effects all suppressed
    drive(64'd9, 32'hFFFF_FFFF, 32'h40, 32'h44, 5'd5, 32'h9999);
    rvfi_trap = 1; trap_cause = 32'd2;
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h1;
    rvfi_mem_addr = 32'h500; rvfi_mem_rmask = 4'b1111; rvfi_mem_rdata = 32'h1;
    e.next_pc = 32'h8000_0100; e.reg_idx = 5; e.reg_val = 32'h1234;
    e.mepc = 32'h40; e.mcause = 32'd2; e.mtval = 32'h0;
    e.ev_valid = 1; e.ev_cause = 32'd2; e.ev_pc = 32'h40;
    go();
    // order skips 10
    drive(64'd11, 32'h0000_0013, 32'h8000_0100, 32'h8000_0104, 5'd0, 32'h0);
    e.next_pc = 32'h8000_0104; e.reg_idx = 0; e.reg_val = 32'h0; e.oerr = 1;
    go();
    // in-order again, flag stays set
    drive(64'd12, 32'h0000_0013, 32'h8000_0104, 32'h8000_0108, 5'd0, 32'h0);
    e.next_pc = 32'h8000_0108;
    go();
    repeat (3) @(posedge clock);
    #1;

    // retire captured, then reset hits before the packet can be observed
    drive(64'd13, 32'h0000_0013, 32'h8000_0108, 32'h8000_010C, 5'd8, 32'hABCD);
    @(posedge clock);
    #1;
    reset = 1;
    idle();
    @(negedge clock);
    chk("midrst_commit_valid", 32'(instCommit_valid), 32'h0);
    chk("midrst_result_pc", result_pc, 32'h0);
    chk("midrst_gpr8", result_regs[32*8 +: 32], 32'h0);
    chk("midrst_mtvec", result_csr_mtvec, 32'h0);
    chk("midrst_order_error", 32'(order_error), 32'h0);
    @(posedge clock);
    #1;
    reset = 0;
    e = '{default: '0};

    // first retire after reset is compared against order 0
    drive(64'd0, 32'h0330_0193, 32'h0, 32'h4, 5'd3, 32'h33);
    e.next_pc = 32'h4; e.reg_idx = 3; e.reg_val = 32'h33;
    go();
    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
